// File: rtl/instr_fetch_unit.sv
// Fetch stage: the PC register drives a combinational ROM and each fetched word lands in a valid/ready output register.
// Define FETCH_BOUND_CHECK_EN to add fetch_fault and a sticky FAULT state that is entered when pc >= DEPTH.
module instr_fetch_unit #(
    parameter int              DEPTH    = 256,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] rom_addr,
    input  logic [31:0]     rom_data,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted
`ifdef FETCH_BOUND_CHECK_EN
    ,
    output logic            fetch_fault
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    if (DEPTH < 1) begin : g_depth_check
        $error("instr_fetch_unit: DEPTH must be at least 1");
    end

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            pc_out_of_range;
    logic            redirect_take;
    logic            fire;

`ifdef FETCH_BOUND_CHECK_EN
    localparam logic [PC_W:0] DEPTH_EXT = (PC_W+1)'(DEPTH);
    assign pc_out_of_range = ({1'b0, pc_q} >= DEPTH_EXT);
`else
    assign pc_out_of_range = 1'b0;
`endif

    // Redirects are ignored while booting and once the unit has faulted.
    assign redirect_take = redirect_en && (state_q != ST_BOOT) && (state_q != ST_FAULT);
    assign fire = (state_q == ST_RUN) && (!instr_valid_q || instr_ready)
                  && !redirect_en && !halt_req && !pc_out_of_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!redirect_en) begin
                    if (pc_out_of_range) begin
                        state_d = ST_FAULT;
                    end else if (halt_req) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        halted = (state_q == ST_HALT);
`ifdef FETCH_BOUND_CHECK_EN
        fetch_fault = (state_q == ST_FAULT);
`endif
    end

    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (redirect_take) begin
            // The word in the output register is dropped even if decode takes it this cycle.
            pc_d          = redirect_pc;
            instr_valid_d = 1'b0;
        end else if (fire) begin
            instr_d       = rom_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 1'b1;
        end else if (instr_valid_q && instr_ready) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async reset check, and random traffic against a behavioural model.
// The fault-checking sequence is built only when FETCH_BOUND_CHECK_EN is defined.
module tb_instr_fetch_unit;

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        halted;
`ifdef FETCH_BOUND_CHECK_EN
    logic        fetch_fault;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // ROM[k] = k + 0x100 for every address.
    assign rom_data = rom_addr + 32'h100;

    instr_fetch_unit #(.DEPTH(256), .PC_W(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted)
`ifdef FETCH_BOUND_CHECK_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ready;
        logic        ren;
        logic [31:0] rpc;
        logic        halt;
        logic        res;
        logic        exp_valid;
        logic [31:0] exp_ipc;
        logic [31:0] exp_addr;
        logic        exp_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ready, input logic ren, input logic [31:0] rpc,
                                input logic halt, input logic res, input logic v,
                                input logic [31:0] ipc, input logic [31:0] addr, input logic h);
        vec_t r;
        r.ready = ready; r.ren = ren; r.rpc = rpc; r.halt = halt; r.res = res;
        r.exp_valid = v; r.exp_ipc = ipc; r.exp_addr = addr; r.exp_halted = h;
        return r;
    endfunction

    typedef enum int {M_BOOT, M_RUN, M_HALT, M_FAULT} mode_e;
    mode_e       m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic ready, input logic ren, input logic [31:0] rpc,
                         input logic halt, input logic res);
        instr_ready = ready;
        redirect_en = ren;
        redirect_pc = rpc;
        halt_req    = halt;
        resume      = res;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode = M_BOOT; m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    endtask

    // One clock of the fetch rules as seen from the pipeline boundary.
    task automatic model_step(input logic ready, input logic ren, input logic [31:0] rpc,
                              input logic halt, input logic res);
        logic taken;
        taken = m_valid && ready;
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
                if (ren) begin
                    m_pc = rpc; m_valid = 1'b0;
                end else if (BOUND && m_pc >= 32'd256) begin
                    m_mode = M_FAULT;
                    if (taken) m_valid = 1'b0;
                end else if (halt) begin
                    m_mode = M_HALT;
                    if (taken) m_valid = 1'b0;
                end else if (!m_valid || ready) begin
                    m_ipc = m_pc; m_instr = m_pc + 32'h100; m_valid = 1'b1; m_pc = m_pc + 32'd1;
                end
            end
            M_HALT: begin
                if (ren) begin
                    m_pc = rpc; m_valid = 1'b0;
                end else if (taken) begin
                    m_valid = 1'b0;
                end
                if (res && !halt) m_mode = M_RUN;
            end
            default: if (taken) m_valid = 1'b0;
        endcase
    endtask

    initial begin
        rst_n = 1'b0;
        apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("reset_valid", {31'b0, instr_valid}, 32'h0);
        chk("reset_addr", rom_addr, 32'h0);
        chk("reset_halted", {31'b0, halted}, 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // ready, redirect, target, halt, resume | valid, instr_pc, rom_addr, halted
        vecs.push_back(mk(1, 0, 0,    0, 0, 0, 0,    0,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 0,    1,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 1,    2,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 2,    3,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 3,    4,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 4,    5,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 5,    6,    0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 1, 5,    6,    0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 1, 5,    6,    0));
        vecs.push_back(mk(0, 0, 0,    0, 0, 1, 5,    6,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 6,    7,    0));
        vecs.push_back(mk(1, 1, 'h40, 0, 0, 0, 6,    'h40, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 'h40, 'h41, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 'h41, 'h42, 0));
        vecs.push_back(mk(1, 1, 9,    0, 0, 0, 'h41, 9,    0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 9,    10,   0));
        vecs.push_back(mk(0, 0, 0,    1, 0, 1, 9,    10,   1));
        vecs.push_back(mk(0, 0, 0,    0, 0, 1, 9,    10,   1));
        vecs.push_back(mk(1, 0, 0,    0, 0, 0, 9,    10,   1));
        vecs.push_back(mk(1, 0, 0,    0, 0, 0, 9,    10,   1));
        vecs.push_back(mk(1, 0, 0,    0, 1, 0, 9,    10,   0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 10,   11,   0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 11,   12,   0));
        vecs.push_back(mk(1, 0, 0,    1, 1, 0, 11,   12,   1));
        vecs.push_back(mk(1, 0, 0,    1, 1, 0, 11,   12,   1));
        vecs.push_back(mk(1, 0, 0,    0, 1, 0, 11,   12,   0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 12,   13,   0));
        vecs.push_back(mk(1, 1, 'h20, 1, 0, 0, 12,   'h20, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 'h20, 'h21, 0));
        vecs.push_back(mk(1, 0, 0,    1, 0, 0, 'h20, 'h21, 1));
        vecs.push_back(mk(1, 1, 'h30, 0, 0, 0, 'h20, 'h30, 1));
        vecs.push_back(mk(1, 0, 0,    0, 1, 0, 'h20, 'h30, 0));
        vecs.push_back(mk(1, 0, 0,    0, 0, 1, 'h30, 'h31, 0));
        if (!BOUND) begin
            vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 'h30, 32'hFFFF_FFFF, 0));
            vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0));
            vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0));
        end

        foreach (vecs[i]) begin
            apply(vecs[i].ready, vecs[i].ren, vecs[i].rpc, vecs[i].halt, vecs[i].res);
            step();
            $display("vec %0d: valid=%0b instr_pc=0x%08h rom_addr=0x%08h halted=%0b instr=0x%08h",
                     i, instr_valid, instr_pc, rom_addr, halted, instr);
            chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].exp_ipc);
            chk($sformatf("vec%0d_rom_addr", i), rom_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_halted});
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_ipc + 32'h100);
        end

        // Stream up to pc=7, then pull reset between clock edges.
        apply(1, 1, 32'd6, 0, 0);
        step();
        apply(1, 0, 32'd0, 0, 0);
        step();
        chk("pre_reset_instr_pc", instr_pc, 32'd6);
        chk("pre_reset_addr", rom_addr, 32'd7);
        #3 rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0b rom_addr=0x%08h", instr_valid, rom_addr);
        chk("async_reset_valid", {31'b0, instr_valid}, 32'h0);
        chk("async_reset_addr", rom_addr, 32'h0);
        chk("async_reset_instr_pc", instr_pc, 32'h0);
        chk("async_reset_instr", instr, 32'h0);
        chk("async_reset_halted", {31'b0, halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int n = 0; n < 400; n++) begin
            logic        r_ready, r_ren, r_halt, r_res;
            logic [31:0] r_pc;
            r_ready = ($urandom_range(0, 3) != 0);
            r_ren   = (m_mode != M_HALT) && ($urandom_range(0, 11) == 0);
            if (!BOUND && $urandom_range(0, 3) == 0)
                r_pc = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else
                r_pc = 32'($urandom_range(0, 270));
            r_halt = ($urandom_range(0, 11) == 0);
            r_res  = ($urandom_range(0, 4) == 0);
            apply(r_ready, r_ren, r_pc, r_halt, r_res);
            model_step(r_ready, r_ren, r_pc, r_halt, r_res);
            step();
            $display("rnd %0d: valid=%0b instr_pc=0x%08h rom_addr=0x%08h halted=%0b",
                     n, instr_valid, instr_pc, rom_addr, halted);
            chk($sformatf("rnd%0d_valid", n), {31'b0, instr_valid}, {31'b0, m_valid});
            chk($sformatf("rnd%0d_rom_addr", n), rom_addr, m_pc);
            chk($sformatf("rnd%0d_halted", n), {31'b0, halted}, {31'b0, m_mode == M_HALT});
            if (m_valid) begin
                chk($sformatf("rnd%0d_instr_pc", n), instr_pc, m_ipc);
                chk($sformatf("rnd%0d_instr", n), instr, m_instr);
            end
`ifdef FETCH_BOUND_CHECK_EN
            chk($sformatf("rnd%0d_fault", n), {31'b0, fetch_fault}, {31'b0, m_mode == M_FAULT});
`endif
        end

`ifdef FETCH_BOUND_CHECK_EN
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 0, 32'd0, 0, 0);
        step();
        apply(1, 1, 32'd255, 0, 0);
        step();
        chk("fault_redirect_addr", rom_addr, 32'd255);
        apply(1, 0, 32'd0, 0, 0);
        step();
        $display("fault seq: valid=%0b instr_pc=0x%08h fault=%0b", instr_valid, instr_pc, fetch_fault);
        chk("fault_word255_valid", {31'b0, instr_valid}, 32'h1);
        chk("fault_word255_pc", instr_pc, 32'd255);
        chk("fault_word255_instr", instr, 32'h1FF);
        chk("fault_not_yet", {31'b0, fetch_fault}, 32'h0);
        step();
        $display("fault seq: valid=%0b rom_addr=0x%08h fault=%0b", instr_valid, rom_addr, fetch_fault);
        chk("fault_set", {31'b0, fetch_fault}, 32'h1);
        chk("fault_no_word256", {31'b0, instr_valid}, 32'h0);
        apply(1, 1, 32'd0, 0, 0);
        step();
        apply(1, 0, 32'd0, 0, 0);
        step();
        $display("fault seq: valid=%0b rom_addr=0x%08h fault=%0b", instr_valid, rom_addr, fetch_fault);
        chk("fault_redirect_ignored_addr", rom_addr, 32'd256);
        chk("fault_sticky", {31'b0, fetch_fault}, 32'h1);
        chk("fault_still_no_valid", {31'b0, instr_valid}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
